// File: rtl/queue_tx.sv
// Serial transmitter that drains the queue: pops the head entry and sends it as
// start bit, LSB-first data, optional even parity and stop bit, each held DIV cycles.
module queue_tx #(
  parameter int unsigned DW        = 4,
  parameter int unsigned DIV       = 868,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic          clk100,
  input  logic          rst,
  input  logic          en,
  input  logic          q_empty,
  input  logic [DW-1:0] q_data,
  output logic          q_pop,
  output logic          txd,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    sent_cnt
);

  localparam int unsigned BW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] BaudLast = BW'(DIV - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(DW - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e        state_q;
  logic [BW-1:0] baud_q;
  logic [IW-1:0] idx_q;
  logic [DW-1:0] shreg_q;
  logic          par_q;

  logic          baud_end;
  logic [DW-1:0] sh_next;

  assign baud_end = (baud_q == BaudLast);
  assign sh_next  = shreg_q >> 1;
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      q_pop      <= 1'b0;
      txd        <= 1'b1;
      frame_done <= 1'b0;
      sent_cnt   <= '0;
    end else begin
      q_pop      <= 1'b0;
      frame_done <= 1'b0;
      if (state_q != StIdle) begin
        baud_q <= baud_end ? '0 : baud_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          // Head entry is captured here; later queue changes cannot affect this frame.
          if (en && !q_empty) begin
            shreg_q <= q_data;
            par_q   <= ^q_data;
            q_pop   <= 1'b1;
            baud_q  <= '0;
            txd     <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_end) begin
            idx_q   <= '0;
            txd     <= shreg_q[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (baud_end) begin
            shreg_q <= sh_next;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IdxLast) begin
              if (PARITY_EN) begin
                txd     <= par_q;
                state_q <= StParity;
              end else begin
                txd     <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              txd <= sh_next[0];
            end
          end
        end
        StParity: begin
          if (baud_end) begin
            txd     <= 1'b1;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (baud_end) begin
            frame_done <= 1'b1;
            sent_cnt   <= sent_cnt + 8'd1;
            state_q    <= StIdle;
          end
        end
        default: begin
          txd     <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_queue_tx.sv
// Directed bench for queue_tx with DIV=4: a parity instance fed by a small queue
// model or direct drive, and a no-parity instance for the disable-mid-frame case.
module tb_queue_tx;

  logic       clk100 = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       q_empty;
  logic [3:0] q_data;
  logic       q_pop, txd, busy, frame_done;
  logic [7:0] sent_cnt;

  logic       en2 = 1'b0;
  logic       q_empty2 = 1'b1;
  logic [3:0] q_data2 = 4'h0;
  logic       q_pop2, txd2, busy2, frame_done2;
  logic [7:0] sent_cnt2;

  // Queue model or direct drive for the parity instance
  logic        model_on = 1'b0;
  logic [3:0]  qmem [4];
  int unsigned qhead = 0;
  int unsigned qcount = 0;
  logic        q_empty_drv = 1'b1;
  logic [3:0]  q_data_drv = 4'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk100 = ~clk100;

  always_comb begin
    q_data  = model_on ? qmem[qhead[1:0]] : q_data_drv;
    q_empty = model_on ? (qhead >= qcount) : q_empty_drv;
  end

  always @(posedge clk100) begin
    if (!model_on) qhead <= 0;
    else if (q_pop) qhead <= qhead + 1;
  end

  queue_tx #(.DW(4), .DIV(4), .PARITY_EN(1'b1)) dut (
    .clk100(clk100), .rst(rst), .en(en), .q_empty(q_empty), .q_data(q_data),
    .q_pop(q_pop), .txd(txd), .busy(busy), .frame_done(frame_done), .sent_cnt(sent_cnt)
  );

  queue_tx #(.DW(4), .DIV(4), .PARITY_EN(1'b0)) dut_np (
    .clk100(clk100), .rst(rst), .en(en2), .q_empty(q_empty2), .q_data(q_data2),
    .q_pop(q_pop2), .txd(txd2), .busy(busy2), .frame_done(frame_done2), .sent_cnt(sent_cnt2)
  );

  typedef struct {
    logic [3:0] data;
    logic [0:6] bits;  // txd per bit slot: start, d0..d3, parity, stop
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int v, input logic [7:0] exp_cnt);
    q_data_drv  = vecs[v].data;
    q_empty_drv = 1'b0;
    en          = 1'b1;
    tick();
    en          = 1'b0;
    q_empty_drv = 1'b1;
    q_data_drv  = ~vecs[v].data;
    for (int k = 0; k < 28; k++) begin
      chk($sformatf("txd v%0d k%0d", v, k), txd, vecs[v].bits[k/4]);
      chk($sformatf("q_pop v%0d k%0d", v, k), q_pop, k == 0);
      chk($sformatf("busy v%0d k%0d", v, k), busy, 1);
      chk($sformatf("frame_done v%0d k%0d", v, k), frame_done, 0);
      tick();
    end
    chk($sformatf("frame_done end v%0d", v), frame_done, 1);
    chk($sformatf("busy end v%0d", v), busy, 0);
    chk($sformatf("txd end v%0d", v), txd, 1);
    chk($sformatf("sent_cnt v%0d", v), sent_cnt, exp_cnt);
    tick();
    chk($sformatf("frame_done after v%0d", v), frame_done, 0);
  endtask

  initial begin
    logic [0:5] nb;
    int n;

    vecs[0] = '{data: 4'hB, bits: 7'b0110111};
    vecs[1] = '{data: 4'h0, bits: 7'b0000001};
    vecs[2] = '{data: 4'hF, bits: 7'b0111101};
    vecs[3] = '{data: 4'h5, bits: 7'b0101001};
    vecs[4] = '{data: 4'h1, bits: 7'b0100011};
    vecs[5] = '{data: 4'h6, bits: 7'b0011001};

    // Reset values
    repeat (3) tick();
    chk("txd in reset", txd, 1);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("reset txd", txd, 1);
      chk("reset busy", busy, 0);
      chk("reset q_pop", q_pop, 0);
      chk("reset sent_cnt", sent_cnt, 0);
      tick();
    end

    // Single frame 4'b1011
    run_frame(0, 8'd1);

    // Empty queue with en high
    en = 1'b1;
    q_empty_drv = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("empty q_pop", q_pop, 0);
      chk("empty txd", txd, 1);
      chk("empty busy", busy, 0);
    end
    en = 1'b0;
    tick();

    run_frame(4, 8'd2);
    run_frame(5, 8'd3);

    // Clean reset before the stream so sent_cnt restarts at 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst sent_cnt", sent_cnt, 0);
    tick();

    // Back-to-back stream of 0, F, 5 from the queue model
    qmem[0] = 4'h0;
    qmem[1] = 4'hF;
    qmem[2] = 4'h5;
    qmem[3] = 4'h9;
    qcount = 3;
    model_on = 1'b1;
    en = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 29; k++) begin
        if (k < 28) begin
          chk($sformatf("stream txd f%0d k%0d", f, k), txd, vecs[f+1].bits[k/4]);
        end else begin
          chk($sformatf("stream idle txd f%0d", f), txd, 1);
          chk($sformatf("stream idle busy f%0d", f), busy, 0);
          chk($sformatf("stream frame_done f%0d", f), frame_done, 1);
        end
        chk($sformatf("stream q_pop f%0d k%0d", f, k), q_pop, k == 0);
        tick();
      end
    end
    for (int i = 0; i < 10; i++) begin
      chk("stream tail q_pop", q_pop, 0);
      chk("stream tail busy", busy, 0);
      tick();
    end
    chk("stream q_empty", q_empty, 1);
    chk("stream sent_cnt", sent_cnt, 3);
    en = 1'b0;
    model_on = 1'b0;
    tick();

    // No-parity instance: drop en at cycle 6, frame still completes, no second pop
    nb = 6'b000011;
    q_data2 = 4'h8;
    q_empty2 = 1'b0;
    en2 = 1'b1;
    tick();
    for (int k = 0; k < 24; k++) begin
      if (k == 6) en2 = 1'b0;
      chk($sformatf("np txd k%0d", k), txd2, nb[k/4]);
      chk($sformatf("np q_pop k%0d", k), q_pop2, k == 0);
      chk($sformatf("np busy k%0d", k), busy2, 1);
      tick();
    end
    chk("np frame_done", frame_done2, 1);
    chk("np busy end", busy2, 0);
    chk("np sent_cnt", sent_cnt2, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("np no second pop", q_pop2, 0);
      chk("np stays idle", busy2, 0);
    end
    q_empty2 = 1'b1;

    // Reset asserted mid-DATA on a zero word
    q_data_drv = 4'h0;
    q_empty_drv = 1'b0;
    en = 1'b1;
    tick();
    en = 1'b0;
    q_empty_drv = 1'b1;
    repeat (9) tick();
    chk("mid txd low", txd, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst txd", txd, 1);
    chk("async rst busy", busy, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("post rst frame_done", frame_done, 0);
      chk("post rst txd", txd, 1);
      tick();
    end
    chk("post rst sent_cnt", sent_cnt, 0);

    // 256 streamed frames wrap sent_cnt
    q_data_drv = 4'hA;
    q_empty_drv = 1'b0;
    en = 1'b1;
    n = 0;
    for (int c = 0; c < 256 * 29 + 200 && n < 256; c++) begin
      tick();
      if (frame_done) begin
        n++;
        if (n == 255) chk("sent_cnt 255", sent_cnt, 255);
      end
    end
    en = 1'b0;
    q_empty_drv = 1'b1;
    chk("frames sent", n, 256);
    chk("sent_cnt wrap", sent_cnt, 0);
    tick();
    tick();
    chk("idle after wrap", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
